// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit. It turns byte-addressed byte, half and word requests into
// word accesses on a memory that writes on its strobe edge and reads combinationally.
module mem_access_unit #(
    parameter int MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_wr,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE, LOAD, RMW_RD, WR_SETUP, WR_PULSE, WR_HOLD, RESP
    } state_t;

    state_t      state, state_nxt;
    logic [1:0]  size_r;
    logic [1:0]  lane_r;
    logic        signed_r;
    logic [31:0] wdata_r;
    logic        accept;
    logic        req_bad;

    function automatic logic req_error(input logic [31:0] addr, input logic [1:0] size);
        logic bad;
        bad = 1'b0;
        case (size)
            2'b00:   bad = 1'b0;
            2'b01:   bad = addr[0];
            2'b10:   bad = (addr[1:0] != 2'b00);
            default: bad = 1'b1;
        endcase
        if ({2'b00, addr[31:2]} >= 32'(MEM_WORDS))
            bad = 1'b1;
        return bad;
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] lane,
                                                 input logic [1:0] size, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   res = sgn ? {{24{b[7]}}, b} : {24'h0, b};
            2'b01:   res = sgn ? {{16{h[15]}}, h} : {16'h0, h};
            default: res = word;
        endcase
        return res;
    endfunction

    // Replace only the addressed lane(s); the rest of the old word passes through untouched.
    function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wd,
                                                input logic [1:0] lane, input logic [1:0] size);
        logic [31:0] res;
        res = old;
        case (size)
            2'b00: res[{lane, 3'b000} +: 8] = wd[7:0];
            2'b01: begin
                if (lane[1])
                    res[31:16] = wd[15:0];
                else
                    res[15:0] = wd[15:0];
            end
            default: res = wd;
        endcase
        return res;
    endfunction

    assign req_ready = (state == IDLE);
    assign accept    = req_valid & req_ready;
    assign req_bad   = req_error(req_addr, req_size);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_bad)
                        state_nxt = RESP;
                    else if (!req_wr)
                        state_nxt = LOAD;
                    else if (req_size == 2'b10)
                        state_nxt = WR_SETUP;
                    else
                        state_nxt = RMW_RD;
                end
            end
            LOAD:     state_nxt = RESP;
            RMW_RD:   state_nxt = WR_SETUP;
            WR_SETUP: state_nxt = WR_PULSE;
            WR_PULSE: state_nxt = WR_HOLD;
            WR_HOLD:  state_nxt = RESP;
            RESP:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Strobe and response are decoded from the next state so both leave a flop cleanly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            size_r     <= 2'b00;
            lane_r     <= 2'b00;
            signed_r   <= 1'b0;
            wdata_r    <= 32'h0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'h0;
            mem_addr   <= 32'h0;
            mem_wdata  <= 32'h0;
            mem_wr     <= 1'b0;
        end else begin
            state      <= state_nxt;
            resp_valid <= (state_nxt == RESP);
            mem_wr     <= (state_nxt == WR_PULSE);
            case (state)
                IDLE: begin
                    if (accept) begin
                        size_r   <= req_size;
                        lane_r   <= req_addr[1:0];
                        signed_r <= req_signed;
                        wdata_r  <= req_wdata;
                        if (req_bad) begin
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'h0;
                        end else begin
                            mem_addr <= {2'b00, req_addr[31:2]};
                            if (req_wr && req_size == 2'b10)
                                mem_wdata <= req_wdata;
                        end
                    end
                end
                LOAD: begin
                    resp_err   <= 1'b0;
                    resp_rdata <= load_extract(mem_rdata, lane_r, size_r, signed_r);
                end
                RMW_RD: mem_wdata <= store_merge(mem_rdata, wdata_r, lane_r, size_r);
                WR_HOLD: begin
                    resp_err   <= 1'b0;
                    resp_rdata <= 32'h0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural edge-written word memory.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wr = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_wr;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:1023];
    int          wr_count = 0;
    logic [31:0] last_wr_addr = 32'h0;
    logic [31:0] last_wr_data = 32'h0;
    logic        hold_bad = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;

    mem_access_unit #(.MEM_WORDS(1024)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
        .resp_rdata(resp_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wr(mem_wr), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = (mem_addr < 32'd1024) ? mem[mem_addr[9:0]] : 32'h0;

    always @(posedge mem_wr) begin
        wr_count++;
        last_wr_addr = mem_addr;
        last_wr_data = mem_wdata;
        if (mem_addr < 32'd1024)
            mem[mem_addr[9:0]] = mem_wdata;
    end

    always @(negedge clk)
        if (mem_wr && (mem_addr != last_wr_addr || mem_wdata != last_wr_data))
            hold_bad = 1'b1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic run_req(input logic wr, input logic [1:0] size, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output int lat, output logic [31:0] rd, output logic er);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        req_valid = 1'b1; req_wr = wr; req_size = size; req_signed = sgn;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0; req_wdata = 32'hx; req_addr = 32'hx;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = resp_rdata;
        er = resp_err;
    endtask

    int          lat;
    int          wc;
    logic [31:0] rd;
    logic        er;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[5] = 32'h1111_2222;
        mem[8] = 32'hCAFE_F00D;

        #12;
        check("reset_ready", 32'(req_ready), 32'd1);
        check("reset_mem_wr", 32'(mem_wr), 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // Word store then word load
        wc = wr_count;
        run_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, lat, rd, er);
        check("st_word_lat", 32'(lat), 32'd4);
        check("st_word_err", 32'(er), 32'd0);
        check("st_word_rdata", rd, 32'h0);
        check("st_word_pulses", 32'(wr_count - wc), 32'd1);
        check("st_word_addr", last_wr_addr, 32'd4);
        check("st_word_data", last_wr_data, 32'hDEAD_BEEF);
        run_req(1'b0, 2'b10, 1'b1, 32'h10, 32'h0, lat, rd, er);
        check("ld_word_lat", 32'(lat), 32'd2);
        check("ld_word_rdata", rd, 32'hDEAD_BEEF);
        check("ld_word_err", 32'(er), 32'd0);

        // Byte read-modify-write and byte loads
        run_req(1'b1, 2'b00, 1'b0, 32'h12, 32'hFFFF_FF5A, lat, rd, er);
        check("st_byte_lat", 32'(lat), 32'd5);
        check("st_byte_mem", mem[4], 32'hDE5A_BEEF);
        run_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, lat, rd, er);
        check("ld_byte_s", rd, 32'hFFFF_FFDE);
        run_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, lat, rd, er);
        check("ld_byte_u", rd, 32'h0000_00DE);
        run_req(1'b0, 2'b00, 1'b1, 32'h12, 32'h0, lat, rd, er);
        check("ld_byte_lane2", rd, 32'h0000_005A);

        // Half store into upper lane, then loads
        run_req(1'b1, 2'b01, 1'b0, 32'h16, 32'h0000_8001, lat, rd, er);
        check("st_half_lat", 32'(lat), 32'd5);
        check("st_half_mem", mem[5], 32'h8001_2222);
        run_req(1'b0, 2'b01, 1'b1, 32'h16, 32'h0, lat, rd, er);
        check("ld_half_s", rd, 32'hFFFF_8001);
        check("ld_half_lat", 32'(lat), 32'd2);
        run_req(1'b0, 2'b01, 1'b0, 32'h14, 32'h0, lat, rd, er);
        check("ld_half_lo_u", rd, 32'h0000_2222);

        // Error cases
        wc = wr_count;
        run_req(1'b0, 2'b01, 1'b0, 32'h11, 32'h0, lat, rd, er);
        check("err_half_err", 32'(er), 32'd1);
        check("err_half_rdata", rd, 32'h0);
        check("err_half_lat", 32'(lat), 32'd1);
        run_req(1'b1, 2'b10, 1'b0, 32'h1000, 32'h1234_5678, lat, rd, er);
        check("err_range_err", 32'(er), 32'd1);
        check("err_range_lat", 32'(lat), 32'd1);
        run_req(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, lat, rd, er);
        check("err_size_err", 32'(er), 32'd1);
        run_req(1'b1, 2'b10, 1'b0, 32'h12, 32'h0BAD_0BAD, lat, rd, er);
        check("err_misalign_err", 32'(er), 32'd1);
        check("err_no_writes", 32'(wr_count - wc), 32'd0);
        check("err_mem4_kept", mem[4], 32'hDE5A_BEEF);
        @(posedge clk); #1;
        check("resp_err_holds", 32'(resp_err), 32'd1);

        // Asynchronous reset in the middle of a load
        run_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, lat, rd, er);
        @(negedge clk);
        req_valid = 1'b1; req_wr = 1'b0; req_size = 2'b10; req_addr = 32'h10;
        @(posedge clk); #1;
        req_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_ld_ready", 32'(req_ready), 32'd1);
        check("rst_ld_rvalid", 32'(resp_valid), 32'd0);
        check("rst_ld_rdata", resp_rdata, 32'h0);
        check("rst_ld_maddr", mem_addr, 32'h0);
        check("rst_ld_mwdata", mem_wdata, 32'h0);
        check("rst_ld_mwr", 32'(mem_wr), 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // Asynchronous reset during WR_SETUP of a store
        wc = wr_count;
        @(negedge clk);
        req_valid = 1'b1; req_wr = 1'b1; req_size = 2'b10;
        req_addr = 32'h20; req_wdata = 32'h1234_5678;
        @(posedge clk); #1;
        req_valid = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_st_mwr", 32'(mem_wr), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(posedge clk);
        check("rst_st_no_write", 32'(wr_count - wc), 32'd0);
        check("rst_st_mem8", mem[8], 32'hCAFE_F00D);
        run_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, lat, rd, er);
        check("post_rst_lat", 32'(lat), 32'd2);
        check("post_rst_rdata", rd, 32'hCAFE_F00D);
        check("post_rst_err", 32'(er), 32'd0);

        check("wr_hold_stable", 32'(hold_bad), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
